rf_wr_arbiter: RTL and testbench

Round-robin write-port arbiter for the 32x32 integer register file. It sits between several writeback sources (ALU, load unit, debug/CSR path) and the register file's single write port. Each cycle it grants at most one request and registers the winner's destination and data. It then drives the register file write controls (`wr_en`, `rd_addr`, `data_in`) one cycle later. It also exports a pending-destination mask for decode hazard checks and a saturating contention counter.

---
 rtl/rf_wr_arbiter.sv | 100 ++++++++++
 tb/tb_rf_wr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter that funnels several writeback sources onto the single
// register-file write port, with a pending-destination mask and a contention counter.
module rf_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic              wr_en,
  output logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     data_in,
  output logic [1:0]        grant_id,
  output logic [31:0]       pend_mask,
  output logic [15:0]       conflict_cnt
);

  logic [1:0]    last_q;
  logic          wr_en_q;
  logic [AW-1:0] rd_addr_q;
  logic [DW-1:0] data_q;
  logic [1:0]    grant_q;
  logic [15:0]   conflict_q;

  logic          found;
  logic [1:0]    gnt_idx;
  logic          accept;
  logic          contended;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Search starts just after the previous winner and wraps, so each valid
  // requester is reached within NREQ accepts.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = 2'(idx);
      end
    end
  end

  assign accept    = found && !stall && rst_n;
  assign contended = $countones(req_valid) >= 2;

  always_comb begin
    int sel;
    sel      = int'(gnt_idx);
    sel_addr = req_addr[sel*AW +: AW];
    sel_data = req_data[sel*DW +: DW];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (gnt_idx == 2'(gi));
    end
  endgenerate

  // Writes to x0 are consumed but never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 2'(NREQ - 1);
      wr_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      conflict_q <= '0;
    end else begin
      wr_en_q <= accept && !flush && (sel_addr != '0);
      if (accept) begin
        rd_addr_q <= sel_addr;
        data_q    <= sel_data;
        grant_q   <= gnt_idx;
        last_q    <= gnt_idx;
      end
      if (contended && conflict_q != 16'hFFFF) begin
        conflict_q <= conflict_q + 16'd1;
      end
    end
  end

  assign wr_en        = wr_en_q;
  assign rd_addr      = rd_addr_q;
  assign data_in      = data_q;
  assign grant_id     = grant_q;
  assign conflict_cnt = conflict_q;
  assign pend_mask    = wr_en_q ? (32'd1 << rd_addr_q) : 32'd0;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: grant order, x0 writes, stall, flush,
// counter saturation and asynchronous reset.
module tb_rf_wr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic              flush;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic              wr_en;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     data_in;
  logic [1:0]        grant_id;
  logic [31:0]       pend_mask;
  logic [15:0]       conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .wr_en(wr_en), .rd_addr(rd_addr), .data_in(data_in),
    .grant_id(grant_id), .pend_mask(pend_mask), .conflict_cnt(conflict_cnt)
  );

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    req_valid = 3'b111; req_addr = '0; req_data = '0;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    @(negedge clk); @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL reset_pend got=%h exp=0", pend_mask); end
    checks++; if (conflict_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", conflict_cnt); end
    checks++; if (rd_addr !== 5'd0 || data_in !== 32'h0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL reset_regs got addr=%0d data=%h gid=%0d exp=0/0/0", rd_addr, data_in, grant_id);
    end
    req_valid = '0;
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b1 || rd_addr !== 5'd5 || data_in !== 32'hDEADBEEF || grant_id !== 2'd0) begin
      errors++; $display("FAIL single_out got we=%b addr=%0d data=%h gid=%0d exp 1/5/deadbeef/0", wr_en, rd_addr, data_in, grant_id);
    end
    checks++; if (pend_mask !== 32'h20) begin errors++; $display("FAIL single_pend got=%h exp=00000020", pend_mask); end
    @(negedge clk);
    req_valid = '0;
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    int e;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      e = c % 3;
      exp_rdy = 3'b001 << e;
      #1;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, req_ready, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (grant_id !== 2'(e) || rd_addr !== 5'(e + 1) || wr_en !== 1'b1 || data_in !== 32'hA000_0000 + 32'(e)) begin
        errors++; $display("FAIL rr_out[%0d] got gid=%0d addr=%0d we=%b data=%h exp gid=%0d", c, grant_id, rd_addr, wr_en, data_in, e);
      end
      $display("rr cycle %0d grant=%0d addr=%0d", c, grant_id, rd_addr);
      @(negedge clk);
    end
    req_valid = '0;
    checks++; if (conflict_cnt !== 16'd6) begin errors++; $display("FAIL rr_cnt got=%0d exp=6", conflict_cnt); end
  endtask

  task automatic test_x0();
    // pointer is at 2, so search starts at 0; only requester 1 is valid
    set_req(1, 5'd0, 32'h1234);
    req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL x0_ready got=%b exp=010", req_ready); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b0 || pend_mask !== 32'h0) begin
      errors++; $display("FAIL x0_out got we=%b pend=%h exp 0/0", wr_en, pend_mask);
    end
    checks++; if (grant_id !== 2'd1 || data_in !== 32'h1234) begin
      errors++; $display("FAIL x0_regs got gid=%0d data=%h exp 1/00001234", grant_id, data_in);
    end
    @(negedge clk);
    req_valid = '0;
    $display("test_x0 done");
  endtask

  task automatic test_stall();
    set_req(2, 5'd9, 32'h55);
    req_valid = 3'b100;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=000", c, req_ready); end
      @(posedge clk); #1;
      checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL stall_we[%0d] got=%b exp=0", c, wr_en); end
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL unstall_ready got=%b exp=100", req_ready); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b1 || rd_addr !== 5'd9 || grant_id !== 2'd2) begin
      errors++; $display("FAIL unstall_out got we=%b addr=%0d gid=%0d exp 1/9/2", wr_en, rd_addr, grant_id);
    end
    @(negedge clk);
    req_valid = '0;
    $display("test_stall done");
  endtask

  task automatic test_flush();
    set_req(0, 5'd7, 32'h77);
    set_req(1, 5'd11, 32'hBB);
    req_valid = 3'b001;
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL flush_ready got=%b exp=001", req_ready); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b0 || pend_mask !== 32'h0) begin
      errors++; $display("FAIL flush_we got we=%b pend=%h exp 0/0", wr_en, pend_mask);
    end
    @(negedge clk);
    flush = 1'b0;
    req_valid = 3'b011;
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL flush_ptr got=%b exp=010", req_ready); end
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b1 || rd_addr !== 5'd11 || grant_id !== 2'd1) begin
      errors++; $display("FAIL flush_next got we=%b addr=%0d gid=%0d exp 1/11/1", wr_en, rd_addr, grant_id);
    end
    @(negedge clk);
    req_valid = '0;
    $display("test_flush done");
  endtask

  task automatic test_saturation();
    do_reset();
    set_req(0, 5'd3, 32'h3);
    set_req(1, 5'd4, 32'h4);
    req_valid = 3'b011;
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (conflict_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got=%h exp=fffe", conflict_cnt); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++; if (conflict_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold[%0d] got=%h exp=ffff", c, conflict_cnt); end
    end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL sat_midwrite got we=%b exp=1", wr_en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || pend_mask !== 32'h0 || req_ready !== 3'b000) begin
      errors++; $display("FAIL async_rst got we=%b pend=%h rdy=%b exp 0/0/000", wr_en, pend_mask, req_ready);
    end
    checks++; if (conflict_cnt !== 16'h0 || rd_addr !== 5'd0 || data_in !== 32'h0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL async_rst_regs got cnt=%h addr=%0d data=%h gid=%0d exp 0", conflict_cnt, rd_addr, data_in, grant_id);
    end
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_stall();
    test_flush();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
